pcie_tx_scheduler: RTL and testbench
====================================

Name: pcie_tx_scheduler

Overview:
Upstream arbiter for the PHY TX mux stage. It selects each cycle among ordered sets, internally generated SKP ordered sets, DLLPs, multi-beat TLPs and idle. It produces the registered 2-bit select code (00 TLP, 01 DLLP, 10 ordered set, 11 idle) together with the registered beat, so the mux and the downstream encoder see aligned select and data. It also keeps TLPs atomic and enforces periodic SKP insertion.

Parameters:
DATA_WIDTH, 128, beat width of all data paths.
SKP_INTERVAL, 1180, cycles of link_up between SKP requests (minimum 2).
SKP_PATTERN, {16{8'hAA}}, beat emitted for an internal SKP ordered set.
IDLE_PATTERN, 128'h0, beat emitted when idle.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
link_up  in  1  1 = L0, data traffic allowed
tlp_valid  in  1  TLP beat valid
tlp_data  in  DATA_WIDTH  TLP beat
tlp_last  in  1  final beat of TLP
tlp_ready  out  1  TLP beat accepted this cycle
dllp_valid  in  1  DLLP beat valid (single-beat)
dllp_data  in  DATA_WIDTH  DLLP beat
dllp_ready  out  1  DLLP accepted this cycle
os_valid  in  1  LTSSM ordered-set beat valid
os_data  in  DATA_WIDTH  ordered-set beat
os_ready  out  1  ordered set accepted this cycle
sel  out  2  registered select code for mux
data_out  out  DATA_WIDTH  registered beat
skp_inserted  out  1  pulse, aligned with SKP beat on data_out
tlp_underrun  out  1  pulse, aligned with idle beat inserted mid-TLP

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: sel=2'b11, data_out=IDLE_PATTERN, skp_inserted=0, tlp_underrun=0, state=ARB, skp counter=0, skp_pending=0. The *_ready outputs are combinational and are 0 while reset=1.
- Handshake: a transfer occurs when valid&ready. Ready is combinational from state, link_up, skp_pending and the valids. At most one ready is high per cycle. The accepted beat appears on data_out with its sel code on the next edge, so latency is 1 cycle. With no transfer, the next cycle is idle (sel=11, IDLE_PATTERN), except for an SKP insertion.
- States: ARB and TLP_BURST.
- ARB, link_up=1, priority: os_valid > skp_pending > dllp_valid > tlp_valid > idle.
  - An accepted TLP beat with tlp_last=0 moves the FSM to TLP_BURST.
  - A single-beat TLP (tlp_last=1) stays in ARB.
- SKP insertion: happens in ARB when skp_pending=1 and os_valid=0. No ready is asserted. The next cycle shows sel=10, data_out=SKP_PATTERN and skp_inserted=1. skp_pending is cleared.
- TLP_BURST: only tlp_ready may assert; os, SKP and DLLP wait.
  - tlp_valid=0: emit idle, pulse tlp_underrun, stay in TLP_BURST.
  - Accepted beat with tlp_last=1: return to ARB.
- link_up=0:
  - Only ordered sets are accepted; tlp_ready=dllp_ready=0.
  - The skp counter is held at 0 and skp_pending is cleared.
  - If in TLP_BURST, the FSM aborts to ARB on the same edge.
- SKP timer: counts while link_up=1. On reaching SKP_INTERVAL-1 it wraps to 0 and sets skp_pending. Requests do not accumulate: an expiry while already pending leaves one request. If expiry and insertion happen on the same edge, pending stays 1.
- Simultaneous valids: losers hold valid and data (source obligation) and are served in later cycles by the same priority order.
- Reset mid-burst: returns to ARB with reset values. A partially sent TLP is not resumed.

Test Plan:
- Reset, then link_up=1 with no valids -> sel=11, data_out=0 every cycle; the first skp_inserted occurs on cycle SKP_INTERVAL+1 after link_up rises, with sel=10 and data_out=SKP_PATTERN.
- In ARB, os_valid, dllp_valid and tlp_valid all 1 -> os_ready then dllp_ready then tlp_ready on consecutive cycles; sel sequence 10,01,00 one cycle later.
- 4-beat TLP (beats 0x1..0x4) with dllp_valid and os_valid raised at beat 2 -> all 4 TLP beats are contiguous with sel=00; then the OS beat, then the DLLP.
- TLP burst with tlp_valid dropped for 2 cycles after beat 1 -> two idle beats with tlp_underrun=1 each; the FSM stays in TLP_BURST and completes on tlp_last.
- SKP expiry during a 6-beat TLP -> SKP is emitted on the cycle right after the last TLP beat (unless os_valid); the timer keeps counting, with no double SKP.
- link_up drops mid-TLP with tlp_valid=1 -> tlp_ready=0 the same cycle, state is ARB, skp counter=0; os_valid is still accepted with sel=10.

Source files
------------

// File: rtl/pcie_tx_scheduler.sv
// rtl/pcie_tx_scheduler.sv - TX arbiter feeding the PHY mux: ordered sets, SKP, DLLP, atomic TLPs, idle.
// Select code and beat are registered together so the mux and encoder see them aligned.
module pcie_tx_scheduler #(
  parameter int                    DATA_WIDTH   = 128,
  parameter int                    SKP_INTERVAL = 1180,
  parameter logic [DATA_WIDTH-1:0] SKP_PATTERN  = {16{8'hAA}},
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  link_up,
  input  logic                  tlp_valid,
  input  logic [DATA_WIDTH-1:0] tlp_data,
  input  logic                  tlp_last,
  output logic                  tlp_ready,
  input  logic                  dllp_valid,
  input  logic [DATA_WIDTH-1:0] dllp_data,
  output logic                  dllp_ready,
  input  logic                  os_valid,
  input  logic [DATA_WIDTH-1:0] os_data,
  output logic                  os_ready,
  output logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  skp_inserted,
  output logic                  tlp_underrun
);

  localparam int CW = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [CW-1:0] SKP_LAST = CW'(SKP_INTERVAL - 1);

  localparam logic [1:0] SEL_TLP  = 2'b00;
  localparam logic [1:0] SEL_DLLP = 2'b01;
  localparam logic [1:0] SEL_OS   = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  typedef enum logic [0:0] {
    ARB       = 1'b0,
    TLP_BURST = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           skp_cnt;
  logic                    skp_pending;
  logic                    skp_go;
  logic                    underrun_go;
  logic [1:0]              sel_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;

  // With the link down the burst is abandoned, so ordered sets are served as if in ARB.
  always_comb begin
    os_ready    = 1'b0;
    dllp_ready  = 1'b0;
    tlp_ready   = 1'b0;
    skp_go      = 1'b0;
    underrun_go = 1'b0;
    state_nxt   = state;
    sel_nxt     = SEL_IDLE;
    data_nxt    = IDLE_PATTERN;

    if (!reset) begin
      if (!link_up) begin
        state_nxt = ARB;
        os_ready  = os_valid;
      end else if (state == TLP_BURST) begin
        tlp_ready   = tlp_valid;
        underrun_go = !tlp_valid;
        if (tlp_valid && tlp_last)
          state_nxt = ARB;
      end else begin
        if (os_valid)
          os_ready = 1'b1;
        else if (skp_pending)
          skp_go = 1'b1;
        else if (dllp_valid)
          dllp_ready = 1'b1;
        else if (tlp_valid) begin
          tlp_ready = 1'b1;
          if (!tlp_last)
            state_nxt = TLP_BURST;
        end
      end
    end

    if (os_ready) begin
      sel_nxt  = SEL_OS;
      data_nxt = os_data;
    end else if (skp_go) begin
      sel_nxt  = SEL_OS;
      data_nxt = SKP_PATTERN;
    end else if (dllp_ready) begin
      sel_nxt  = SEL_DLLP;
      data_nxt = dllp_data;
    end else if (tlp_ready) begin
      sel_nxt  = SEL_TLP;
      data_nxt = tlp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB;
      sel          <= SEL_IDLE;
      data_out     <= IDLE_PATTERN;
      skp_inserted <= 1'b0;
      tlp_underrun <= 1'b0;
    end else begin
      state        <= state_nxt;
      sel          <= sel_nxt;
      data_out     <= data_nxt;
      skp_inserted <= skp_go;
      tlp_underrun <= underrun_go;
    end
  end

  // An expiry on the same edge as an insertion re-arms the request rather than losing it.
  always_ff @(posedge clk) begin
    if (reset || !link_up) begin
      skp_cnt     <= '0;
      skp_pending <= 1'b0;
    end else if (skp_cnt == SKP_LAST) begin
      skp_cnt     <= '0;
      skp_pending <= 1'b1;
    end else begin
      skp_cnt <= skp_cnt + CW'(1);
      if (skp_go)
        skp_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcie_tx_scheduler.sv
// tb/tb_pcie_tx_scheduler.sv - directed self-checking bench for pcie_tx_scheduler.
module tb_pcie_tx_scheduler;

  localparam int DW = 128;
  localparam int SKPI = 20;
  localparam logic [DW-1:0] SKP_PAT = {16{8'hAA}};

  logic          clk = 1'b0;
  logic          reset;
  logic          link_up;
  logic          tlp_valid, tlp_last, tlp_ready;
  logic [DW-1:0] tlp_data;
  logic          dllp_valid, dllp_ready;
  logic [DW-1:0] dllp_data;
  logic          os_valid, os_ready;
  logic [DW-1:0] os_data;
  logic [1:0]    sel;
  logic [DW-1:0] data_out;
  logic          skp_inserted, tlp_underrun;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pcie_tx_scheduler #(.DATA_WIDTH(DW), .SKP_INTERVAL(SKPI)) dut (
    .clk(clk), .reset(reset), .link_up(link_up),
    .tlp_valid(tlp_valid), .tlp_data(tlp_data), .tlp_last(tlp_last), .tlp_ready(tlp_ready),
    .dllp_valid(dllp_valid), .dllp_data(dllp_data), .dllp_ready(dllp_ready),
    .os_valid(os_valid), .os_data(os_data), .os_ready(os_ready),
    .sel(sel), .data_out(data_out), .skp_inserted(skp_inserted), .tlp_underrun(tlp_underrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; link_up = 1'b0;
    tlp_valid = 1'b0; tlp_last = 1'b0; tlp_data = '0;
    dllp_valid = 1'b0; dllp_data = '0;
    os_valid = 1'b0; os_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1; link_up = 1'b1; os_valid = 1'b1; dllp_valid = 1'b1; tlp_valid = 1'b1;
    #1;
    total++; if ({os_ready, dllp_ready, tlp_ready} !== 3'b000) $display("FAIL reset_ready got %b exp 000", {os_ready, dllp_ready, tlp_ready}); else passed++;
    tick(); tick();
    total++; if (sel !== 2'b11) $display("FAIL reset_sel got %b exp 11", sel); else passed++;
    total++; if (data_out !== '0) $display("FAIL reset_data got %h exp 0", data_out); else passed++;
    total++; if ({skp_inserted, tlp_underrun} !== 2'b00) $display("FAIL reset_pulses got %b exp 00", {skp_inserted, tlp_underrun}); else passed++;
    total++; if (dut.skp_cnt !== '0) $display("FAIL reset_skp_cnt got %0d exp 0", dut.skp_cnt); else passed++;
  endtask

  task automatic test_idle_skp();
    int bad;
    do_reset();
    link_up = 1'b1;
    bad = 0;
    for (int k = 1; k <= SKPI; k++) begin
      tick();
      if (sel !== 2'b11 || data_out !== '0 || skp_inserted !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL idle_cycles got %0d bad cycles exp 0", bad); else passed++;
    tick();
    total++; if ({sel, skp_inserted} !== 3'b101) $display("FAIL first_skp got sel=%b skp=%b exp sel=10 skp=1", sel, skp_inserted); else passed++;
    total++; if (data_out !== SKP_PAT) $display("FAIL skp_data got %h exp %h", data_out, SKP_PAT); else passed++;
    tick();
    total++; if ({sel, skp_inserted} !== 3'b110) $display("FAIL after_skp got sel=%b skp=%b exp sel=11 skp=0", sel, skp_inserted); else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    link_up = 1'b1;
    os_valid = 1'b1; os_data = 128'h0505;
    dllp_valid = 1'b1; dllp_data = 128'hD11D;
    tlp_valid = 1'b1; tlp_data = 128'h7777; tlp_last = 1'b1;
    #1;
    total++; if ({os_ready, dllp_ready, tlp_ready} !== 3'b100) $display("FAIL prio_os_ready got %b exp 100", {os_ready, dllp_ready, tlp_ready}); else passed++;
    tick(); os_valid = 1'b0;
    total++; if (sel !== 2'b10 || data_out !== 128'h0505) $display("FAIL prio_os_out got sel=%b data=%h exp sel=10 data=0505", sel, data_out); else passed++;
    #1;
    total++; if ({os_ready, dllp_ready, tlp_ready} !== 3'b010) $display("FAIL prio_dllp_ready got %b exp 010", {os_ready, dllp_ready, tlp_ready}); else passed++;
    tick(); dllp_valid = 1'b0;
    total++; if (sel !== 2'b01 || data_out !== 128'hD11D) $display("FAIL prio_dllp_out got sel=%b data=%h exp sel=01 data=d11d", sel, data_out); else passed++;
    #1;
    total++; if ({os_ready, dllp_ready, tlp_ready} !== 3'b001) $display("FAIL prio_tlp_ready got %b exp 001", {os_ready, dllp_ready, tlp_ready}); else passed++;
    tick(); tlp_valid = 1'b0;
    total++; if (sel !== 2'b00 || data_out !== 128'h7777) $display("FAIL prio_tlp_out got sel=%b data=%h exp sel=00 data=7777", sel, data_out); else passed++;
    tick();
    total++; if (sel !== 2'b11) $display("FAIL prio_idle got sel=%b exp 11", sel); else passed++;
  endtask

  task automatic test_tlp_atomic();
    do_reset();
    link_up = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      tlp_valid = 1'b1; tlp_data = DW'(b); tlp_last = (b == 4);
      if (b == 2) begin
        os_valid = 1'b1; os_data = 128'hAB;
        dllp_valid = 1'b1; dllp_data = 128'hCD;
      end
      #1;
      total++; if ({os_ready, dllp_ready, tlp_ready} !== 3'b001) $display("FAIL atomic_ready beat %0d got %b exp 001", b, {os_ready, dllp_ready, tlp_ready}); else passed++;
      tick();
      total++; if (sel !== 2'b00 || data_out !== DW'(b)) $display("FAIL atomic_beat %0d got sel=%b data=%h exp sel=00 data=%0h", b, sel, data_out, b); else passed++;
    end
    tlp_valid = 1'b0; tlp_last = 1'b0;
    tick(); os_valid = 1'b0;
    total++; if (sel !== 2'b10 || data_out !== 128'hAB) $display("FAIL atomic_os got sel=%b data=%h exp sel=10 data=ab", sel, data_out); else passed++;
    tick(); dllp_valid = 1'b0;
    total++; if (sel !== 2'b01 || data_out !== 128'hCD) $display("FAIL atomic_dllp got sel=%b data=%h exp sel=01 data=cd", sel, data_out); else passed++;
  endtask

  task automatic test_underrun();
    do_reset();
    link_up = 1'b1;
    tlp_valid = 1'b1; tlp_data = 128'h1; tlp_last = 1'b0;
    tick();
    total++; if (sel !== 2'b00 || data_out !== 128'h1) $display("FAIL underrun_beat1 got sel=%b data=%h exp sel=00 data=1", sel, data_out); else passed++;
    tlp_valid = 1'b0; dllp_valid = 1'b1; dllp_data = 128'hEE;
    for (int g = 0; g < 2; g++) begin
      #1;
      total++; if ({dllp_ready, tlp_ready} !== 2'b00) $display("FAIL underrun_gap_ready %0d got %b exp 00", g, {dllp_ready, tlp_ready}); else passed++;
      tick();
      total++; if ({sel, tlp_underrun} !== 3'b111 || data_out !== '0) $display("FAIL underrun_gap %0d got sel=%b ur=%b data=%h exp sel=11 ur=1 data=0", g, sel, tlp_underrun, data_out); else passed++;
    end
    dllp_valid = 1'b0;
    tlp_valid = 1'b1; tlp_data = 128'h2; tlp_last = 1'b1;
    tick();
    total++; if ({sel, tlp_underrun} !== 3'b000 || data_out !== 128'h2) $display("FAIL underrun_last got sel=%b ur=%b data=%h exp sel=00 ur=0 data=2", sel, tlp_underrun, data_out); else passed++;
    tlp_valid = 1'b0; tlp_last = 1'b0; dllp_valid = 1'b1;
    #1;
    total++; if (dllp_ready !== 1'b1) $display("FAIL underrun_back_to_arb got dllp_ready=%b exp 1", dllp_ready); else passed++;
    tick(); dllp_valid = 1'b0;
    total++; if (sel !== 2'b01 || tlp_underrun !== 1'b0) $display("FAIL underrun_dllp got sel=%b ur=%b exp sel=01 ur=0", sel, tlp_underrun); else passed++;
  endtask

  task automatic test_skp_during_tlp();
    int bad;
    do_reset();
    link_up = 1'b1;
    for (int k = 1; k <= 16; k++) tick();
    bad = 0;
    for (int b = 1; b <= 6; b++) begin
      tlp_valid = 1'b1; tlp_data = DW'(16 + b); tlp_last = (b == 6);
      tick();
      if (sel !== 2'b00 || data_out !== DW'(16 + b) || skp_inserted !== 1'b0) bad++;
    end
    tlp_valid = 1'b0; tlp_last = 1'b0;
    total++; if (bad !== 0) $display("FAIL skp_tlp_contiguous got %0d bad beats exp 0", bad); else passed++;
    tick();
    total++; if ({sel, skp_inserted} !== 3'b101 || data_out !== SKP_PAT) $display("FAIL skp_after_tlp got sel=%b skp=%b data=%h exp sel=10 skp=1", sel, skp_inserted, data_out); else passed++;
    bad = 0;
    for (int k = 24; k <= 40; k++) begin
      tick();
      if (skp_inserted !== 1'b0 || sel !== 2'b11) bad++;
    end
    total++; if (bad !== 0) $display("FAIL skp_no_double got %0d bad cycles exp 0", bad); else passed++;
    tick();
    total++; if ({sel, skp_inserted} !== 3'b101) $display("FAIL skp_next_period got sel=%b skp=%b exp sel=10 skp=1", sel, skp_inserted); else passed++;
  endtask

  task automatic test_link_down();
    do_reset();
    link_up = 1'b1;
    tlp_valid = 1'b1; tlp_data = 128'h31; tlp_last = 1'b0;
    tick();
    tlp_data = 128'h32;
    tick();
    total++; if (sel !== 2'b00 || data_out !== 128'h32 || dut.state !== 1'b1) $display("FAIL linkdn_burst got sel=%b data=%h state=%b exp sel=00 data=32 state=1", sel, data_out, dut.state); else passed++;
    link_up = 1'b0; tlp_data = 128'h33;
    #1;
    total++; if (tlp_ready !== 1'b0) $display("FAIL linkdn_tlp_ready got %b exp 0", tlp_ready); else passed++;
    tick();
    total++; if (dut.state !== 1'b0 || dut.skp_cnt !== '0 || sel !== 2'b11) $display("FAIL linkdn_abort got state=%b cnt=%0d sel=%b exp state=0 cnt=0 sel=11", dut.state, dut.skp_cnt, sel); else passed++;
    os_valid = 1'b1; os_data = 128'h7E; dllp_valid = 1'b1;
    #1;
    total++; if ({os_ready, dllp_ready, tlp_ready} !== 3'b100) $display("FAIL linkdn_ready got %b exp 100", {os_ready, dllp_ready, tlp_ready}); else passed++;
    tick(); os_valid = 1'b0; dllp_valid = 1'b0; tlp_valid = 1'b0;
    total++; if (sel !== 2'b10 || data_out !== 128'h7E || skp_inserted !== 1'b0) $display("FAIL linkdn_os got sel=%b data=%h skp=%b exp sel=10 data=7e skp=0", sel, data_out, skp_inserted); else passed++;
    tick();
    total++; if (sel !== 2'b11 || dut.skp_cnt !== '0) $display("FAIL linkdn_hold got sel=%b cnt=%0d exp sel=11 cnt=0", sel, dut.skp_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_idle_skp();
    test_priority();
    test_tlp_atomic();
    test_underrun();
    test_skp_during_tlp();
    test_link_down();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
